hex_display_arbiter: RTL and testbench

- Shares the six on-board seven-segment displays (HEX0..HEX5) between two requesters.
- Requester A is the switch/comparator view; requester B is the birthday view.
- The displayed source changes on a debounced pushbutton press (manual) or a rotation timer (auto, selected by a switch).
- Sits between the display-pattern generators and the board HEX pins.

---
 rtl/hex_display_arbiter.sv | 134 +++++++++++++
 tb/tb_hex_display_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter: shares the six seven-segment displays between the
// switch/comparator view (A) and the birthday view (B). Ownership changes on a
// debounced pushbutton press or, in auto mode, when the dwell timer expires.
module hex_display_arbiter #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned ROT_CYCLES = 64,
   parameter logic [7:0]  BLANK      = 8'hFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        btn_n,
   input  logic        auto_en,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [47:0] seg_a,
   input  logic [47:0] seg_b,
   output logic [7:0]  hex0,
   output logic [7:0]  hex1,
   output logic [7:0]  hex2,
   output logic [7:0]  hex3,
   output logic [7:0]  hex4,
   output logic [7:0]  hex5,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic        press
);

   localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int unsigned RW = (ROT_CYCLES > 1) ? $clog2(ROT_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] ROT_LAST = RW'(ROT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BLANK  = 2'd0,
      ST_SHOW_A = 2'd1,
      ST_SHOW_B = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            deb_q, deb_d;
   logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
   logic            press_q, press_d;
   logic [RW-1:0]   rot_cnt_q, rot_cnt_d;
   logic            rot_expire;
   logic            ev;
   logic [47:0]     src;

   // Button path: two-flop synchronizer, stability counter, falling-edge pulse.
   always_comb begin
      sync1_d   = btn_n;
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_cnt_d = '0;
      if (sync2_q != deb_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            deb_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
         end
      end
      press_d = deb_q & ~deb_d;
   end

   // Ownership FSM and dwell timer; a requester drop outranks a switch event.
   always_comb begin
      rot_expire = (rot_cnt_q == ROT_LAST);
      ev         = press_q | (auto_en & rot_expire);
      state_d    = state_q;
      case (state_q)
         ST_BLANK: begin
            if (req_a)      state_d = ST_SHOW_A;
            else if (req_b) state_d = ST_SHOW_B;
         end
         ST_SHOW_A: begin
            if (!req_a)          state_d = req_b ? ST_SHOW_B : ST_BLANK;
            else if (ev && req_b) state_d = ST_SHOW_B;
         end
         ST_SHOW_B: begin
            if (!req_b)          state_d = req_a ? ST_SHOW_A : ST_BLANK;
            else if (ev && req_a) state_d = ST_SHOW_A;
         end
         default: state_d = ST_BLANK;
      endcase
      // Any event restarts the dwell, so a press with no other requester also
      // resets the timer; expiry is itself an event and therefore wraps to 0.
      if (!auto_en || (state_q == ST_BLANK) || (state_d != state_q) || ev) begin
         rot_cnt_d = '0;
      end else begin
         rot_cnt_d = rot_cnt_q + RW'(1);
      end
   end

   // Display mux and grants decode straight from the state register.
   always_comb begin
      gnt_a = (state_q == ST_SHOW_A);
      gnt_b = (state_q == ST_SHOW_B);
      case (state_q)
         ST_SHOW_A: src = seg_a;
         ST_SHOW_B: src = seg_b;
         default:   src = {6{BLANK}};
      endcase
      hex0  = src[7:0];
      hex1  = src[15:8];
      hex2  = src[23:16];
      hex3  = src[31:24];
      hex4  = src[39:32];
      hex5  = src[47:40];
      press = press_q;
   end

   // All state registers; reset returns to BLANK with the button released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_BLANK;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         deb_q     <= 1'b1;
         deb_cnt_q <= '0;
         press_q   <= 1'b0;
         rot_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_cnt_q <= deb_cnt_d;
         press_q   <= press_d;
         rot_cnt_q <= rot_cnt_d;
      end
   end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios followed by a
// randomized phase, all compared against an edge-by-edge reference model.
module tb_hex_display_arbiter;

   localparam int DEB = 4;
   localparam int ROT = 8;
   localparam logic [47:0] SEG_A0 = 48'h92_99_B0_A4_F9_C0;
   localparam logic [47:0] SEG_B0 = 48'h80_F8_82_92_99_B0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn_n;
   logic        auto_en;
   logic        req_a;
   logic        req_b;
   logic [47:0] seg_a;
   logic [47:0] seg_b;
   logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
   logic        gnt_a, gnt_b, press;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: owner 0 = none, 1 = A, 2 = B.
   int m_own;
   bit m_deb;
   bit m_press;
   int m_r;        // edge index at which the current dwell last restarted
   bit m_hist[$];  // btn_n as sampled at each edge since reset

   hex_display_arbiter #(
      .DEB_CYCLES(DEB),
      .ROT_CYCLES(ROT),
      .BLANK     (8'hFF)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_n  (btn_n),
      .auto_en(auto_en),
      .req_a  (req_a),
      .req_b  (req_b),
      .seg_a  (seg_a),
      .seg_b  (seg_b),
      .hex0   (hex0),
      .hex1   (hex1),
      .hex2   (hex2),
      .hex3   (hex3),
      .hex4   (hex4),
      .hex5   (hex5),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .press  (press)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_own   = 0;
      m_deb   = 1'b1;
      m_press = 1'b0;
      m_r     = 0;
      m_hist.delete();
   endtask

   // One rising edge of the reference: the button is accepted once the
   // synchronized value (two edges late) has disagreed with the accepted level
   // on DEB consecutive edges; a dwell expires ROT edges after its restart.
   task automatic model_edge();
      int  n;
      bit  ev;
      int  nxt;
      bit  flip;
      bit  v;
      n   = m_hist.size();
      ev  = m_press || (auto_en && m_own != 0 && (n - m_r) == ROT);
      nxt = m_own;
      if (m_own == 0) begin
         nxt = req_a ? 1 : (req_b ? 2 : 0);
      end else if (m_own == 1) begin
         if (!req_a)          nxt = req_b ? 2 : 0;
         else if (ev && req_b) nxt = 2;
      end else begin
         if (!req_b)          nxt = req_a ? 1 : 0;
         else if (ev && req_a) nxt = 1;
      end
      if (nxt != m_own || ev || !auto_en || nxt == 0) m_r = n;
      m_own = nxt;
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
         v = (n - 2 - j >= 0) ? m_hist[n - 2 - j] : 1'b1;
         if (v == m_deb) flip = 1'b0;
      end
      m_press = flip && m_deb;
      if (flip) m_deb = ~m_deb;
      m_hist.push_back(btn_n);
   endtask

   function automatic logic [47:0] exp_hex();
      if (m_own == 1)      return seg_a;
      else if (m_own == 2) return seg_b;
      else                 return {6{8'hFF}};
   endfunction

   task automatic check_all(input string tag);
      chk({tag, ".gnt_a"}, {47'b0, gnt_a}, {47'b0, m_own == 1});
      chk({tag, ".gnt_b"}, {47'b0, gnt_b}, {47'b0, m_own == 2});
      chk({tag, ".press"}, {47'b0, press}, {47'b0, m_press});
      chk({tag, ".hex"}, {hex5, hex4, hex3, hex2, hex1, hex0}, exp_hex());
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_all(tag);
   endtask

   // Called 1 time unit after an edge; reset is asserted and released between edges.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      model_reset();
      #1 check_all(tag);
      #2 rst_n = 1'b1;
   endtask

   task automatic run_until_press(input string tag, output int n);
      n = 0;
      do begin
         step(tag);
         n++;
      end while (press !== 1'b1 && n < 20);
      chk({tag, ".latency"}, 48'(n >= DEB + 2 && n <= DEB + 3), 48'(1));
   endtask

   initial begin
      int          n;
      int          cnt;
      int          since;
      logic [1:0]  prev;
      int          btn_left;
      logic [47:0] blank48;

      blank48 = {6{8'hFF}};
      rst_n   = 1'b0;
      btn_n   = 1'b1;
      auto_en = 1'b0;
      req_a   = 1'b0;
      req_b   = 1'b0;
      seg_a   = SEG_A0;
      seg_b   = SEG_B0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // 1. Priority when both request, then asynchronous reset.
      req_a = 1'b1;
      req_b = 1'b1;
      step("prio");
      chk("prio.gnt_a", {47'b0, gnt_a}, 48'(1));
      chk("prio.hex0", 48'(hex0), 48'(8'hC0));
      chk("prio.hex5", 48'(hex5), 48'(8'h92));
      step("prio_hold");
      pulse_reset("midreset");
      chk("midreset.hex", {hex5, hex4, hex3, hex2, hex1, hex0}, blank48);
      step("after_reset");

      // 2. Manual switch, release, and glitch rejection.
      btn_n = 1'b0;
      run_until_press("press1", n);
      step("switch");
      chk("switch.gnt_b", {47'b0, gnt_b}, 48'(1));
      chk("switch.hex0", 48'(hex0), 48'(8'hB0));
      for (int i = n + 1; i < 10; i++) step("btn_hold");
      btn_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step("release");
         cnt += press;
      end
      chk("release.no_press", 48'(cnt), 48'(0));
      btn_n = 1'b0;
      for (int i = 0; i < 3; i++) step("glitch");
      btn_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         step("glitch_after");
         cnt += press;
      end
      chk("glitch.no_press", 48'(cnt), 48'(0));
      chk("glitch.gnt_b", {47'b0, gnt_b}, 48'(1));

      // 3. Auto rotation: five grant changes, each ROT edges apart.
      auto_en = 1'b1;
      prev    = {gnt_a, gnt_b};
      since   = 0;
      cnt     = 0;
      for (int i = 0; i < 60 && cnt < 5; i++) begin
         step("auto");
         since++;
         if ({gnt_a, gnt_b} != prev) begin
            chk("auto.period", 48'(since), 48'(ROT));
            cnt++;
            since = 0;
            prev  = {gnt_a, gnt_b};
         end
      end
      chk("auto.changes", 48'(cnt), 48'(5));
      for (int i = 0; i < 3; i++) step("auto_mid");
      auto_en = 1'b0;
      prev    = {gnt_a, gnt_b};
      cnt     = 0;
      for (int i = 0; i < 30; i++) begin
         step("manual_hold");
         if ({gnt_a, gnt_b} != prev) cnt++;
      end
      chk("manual_hold.changes", 48'(cnt), 48'(0));

      // 4. Drop handling.
      req_a = 1'b1;
      req_b = 1'b0;
      step("to_a");
      step("to_a2");
      req_a = 1'b0;
      step("drop_blank");
      chk("drop_blank.hex", {hex5, hex4, hex3, hex2, hex1, hex0}, blank48);
      chk("drop_blank.gnt", 48'({gnt_a, gnt_b}), 48'(0));
      req_a = 1'b1;
      req_b = 1'b1;
      step("regrant_a");
      btn_n = 1'b0;
      run_until_press("press_drop", n);
      req_a = 1'b0;
      step("drop_with_press");
      chk("drop_with_press.gnt_b", {47'b0, gnt_b}, 48'(1));
      prev = {gnt_a, gnt_b};
      cnt  = 0;
      for (int i = 0; i < 10; i++) begin
         step("no_bounce");
         if ({gnt_a, gnt_b} != prev) cnt++;
         if (i == 3) btn_n = 1'b1;
      end
      chk("no_bounce.changes", 48'(cnt), 48'(0));

      // 5. Single requester in auto mode, then A arrives.
      auto_en = 1'b1;
      cnt     = 0;
      for (int i = 0; i < 30; i++) begin
         step("single_b");
         cnt += gnt_a;
      end
      chk("single_b.gnt_a", 48'(cnt), 48'(0));
      chk("single_b.gnt_b", {47'b0, gnt_b}, 48'(1));
      req_a = 1'b1;
      n     = 0;
      do begin
         step("a_arrives");
         n++;
      end while (gnt_a !== 1'b1 && n < 20);
      chk("a_arrives.within_dwell", 48'(n <= ROT), 48'(1));

      // 6. Reset in the middle of a debounce.
      auto_en = 1'b0;
      btn_n   = 1'b0;
      for (int i = 0; i < 3; i++) step("pre_reset_btn");
      pulse_reset("deb_reset");
      run_until_press("press_after_reset", n);
      btn_n = 1'b1;
      for (int i = 0; i < 8; i++) step("settle");

      // Randomized phase.
      btn_left = 0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0)  req_a = ~req_a;
         if ($urandom_range(0, 9) == 0)  req_b = ~req_b;
         if ($urandom_range(0, 39) == 0) auto_en = ~auto_en;
         if ($urandom_range(0, 3) == 0)  seg_a = 48'({$urandom(), $urandom()});
         if ($urandom_range(0, 3) == 0)  seg_b = 48'({$urandom(), $urandom()});
         if (btn_left == 0) begin
            btn_n    = ~btn_n;
            btn_left = $urandom_range(1, 12);
         end
         btn_left--;
         if ($urandom_range(0, 299) == 0) pulse_reset("rand_reset");
         step("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
